// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares the single-port card-list RAM among NUM_REQ requesters.
// The owner keeps the RAM until it drops req; a hold watchdog forces release and locks it out.
module ram_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 256
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_wren,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       timeout,
  output logic                       busy,
  output logic [ADDR_W-1:0]          ram_address,
  output logic [DATA_W-1:0]          ram_data,
  output logic                       ram_wren,
  input  logic [DATA_W-1:0]          ram_q
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic [HOLD_W-1:0]  hold_count;
  logic [NUM_REQ-1:0] lockout;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] lockout_next;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [31:0]        cand;
  logic               force_release;

  assign eligible      = req & ~lockout;
  assign force_release = (state == OWNED) && req[owner] && (hold_count == HOLD_LAST);
  // Lockout clears once the requester lets go; a forced release locks the current owner.
  assign lockout_next  = (lockout & req) | (force_release ? grant : '0);
  assign rd_data       = ram_q;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = (32'(last_owner) + 32'(k)) % NUM_REQ;
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Grant-gated RAM mux; grant resets asynchronously so ram_wren drops with resetn.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        ram_address = ram_address | req_address[i*ADDR_W +: ADDR_W];
        ram_data    = ram_data | req_data[i*DATA_W +: DATA_W];
        ram_wren    = ram_wren | req_wren[i];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      hold_count <= '0;
      lockout    <= '0;
      rd_valid   <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      timeout  <= 1'b0;
      rd_valid <= grant & req & ~req_wren;
      lockout  <= lockout_next;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= NUM_REQ'(1) << winner;
            owner      <= winner;
            last_owner <= winner;
            hold_count <= '0;
            state      <= OWNED;
            busy       <= 1'b1;
          end
        end
        OWNED: begin
          if (hold_count != HOLD_SAT) begin
            hold_count <= hold_count + HOLD_W'(1);
          end
          if (!req[owner] || force_release) begin
            grant <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
          if (force_release) begin
            timeout <= 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 1024x32 card-list RAM among up to NUM_REQ requesters, for example allocate_memory, add_card, remove_nth_card and split_list.
- Uses round-robin arbitration with ownership held for the whole operation: the owner keeps the RAM until it drops its request.
- Drives the RAM address, data and wren from the owner.
- Returns read-valid strobes to the owner and enforces a hold-time watchdog so a stuck module cannot starve the others.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 10, RAM address width.
- DATA_W, 32, RAM data width.
- MAX_HOLD, 256, maximum consecutive owned cycles before forced release.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request per requester; held high for the whole operation.
- req_address  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened write data, same packing.
- req_wren  in  NUM_REQ  write enable per requester.
- grant  out  NUM_REQ  one-hot ownership; at most one bit set.
- rd_valid  out  NUM_REQ  ram_q holds the owner's read data this cycle.
- rd_data  out  DATA_W  ram_q passed through.
- timeout  out  1  one-cycle pulse on a forced release.
- busy  out  1  high while in OWNED.
- ram_address  out  ADDR_W  to RAM.
- ram_data  out  DATA_W  to RAM.
- ram_wren  out  1  to RAM.
- ram_q  in  DATA_W  from RAM.

Behaviour:

Reset (resetn low, asynchronous):
- grant=0, rd_valid=0, timeout=0, busy=0.
- state=IDLE, hold_count=0, lockout=0.
- last_owner=NUM_REQ-1, so requester 0 wins first.
- ram_wren is forced 0 immediately, including when reset is asserted mid-operation.

States:
- IDLE:
  - grant=0.
  - ram_address=0, ram_data=0, ram_wren=0.
  - Eligible requesters are req & ~lockout.
  - If any requester is eligible, the winner is the first eligible index searching last_owner+1, last_owner+2, … modulo NUM_REQ.
  - On the next edge: grant[winner]=1, owner=winner, last_owner=winner, hold_count=0, state=OWNED.
  - Grant latency: req sampled high at edge k gives grant high after edge k.
- OWNED:
  - ram_address, ram_data and ram_wren are combinational muxes of the owner's req_address, req_data and req_wren, gated by grant.
  - Non-owner inputs are ignored.
  - hold_count increments every edge.
  - If req[owner]=0 at an edge: grant cleared, state=IDLE.
  - If req[owner]=1 and hold_count==MAX_HOLD-1 at an edge:
    - grant cleared; timeout=1 for one cycle.
    - lockout[owner]=1; state=IDLE.
  - The owner must not change address or data in the cycle it drops req; ram_wren is already 0 the cycle after.

Turnaround:
- Every ownership change passes through at least one IDLE cycle with ram_wren=0.
- Minimum gap between two owners is 1 cycle.
- The same requester may win again only if no other requester is eligible.

Read data:
- The RAM registers its address on clock and q is valid after that edge.
- rd_valid[i] is a register set to grant[i] & req[i] & ~req_wren[i], so it is one cycle delayed.
- rd_data = ram_q.

Lockout:
- lockout[i] clears on the first edge where req[i]=0.
- A locked-out requester is skipped by arbitration.

Simultaneous events:
- Owner drops req while others request: release this edge, arbitrate in IDLE on the next.
- Release and timeout on the same edge: release wins; no timeout, no lockout.

Counter:
- hold_count width is clog2(MAX_HOLD)+1.
- hold_count saturates and never wraps.

busy:
- busy = (state==OWNED).

Invariant:
- grant is always one-hot or zero.
- Verification must assert this every cycle.

Test Plan:
- Reset, then req=4'b0001 → grant=0001 one cycle later. Owner writes addr 0x020 data 0x80000000: ram_wren=1, ram_address=0x020. Owner drops req → grant=0 and ram_wren=0 next cycle.
- req=4'b1111 held, each owner releasing after 3 cycles → grant order 0001, 0010, 0100, 1000, 0001, with exactly one IDLE cycle between grants.
- Owner 2 reads addr 0x040 → rd_valid=0100 on the following cycle and rd_data equals the stored word. A write by owner 2 gives rd_valid=0.
- Requester 1 holds req for more than 256 cycles with MAX_HOLD=256:
  - forced release at cycle 256; timeout pulses once.
  - requester 3 is granted next.
  - requester 1 is not re-granted until it lowers and re-raises req.
- resetn driven low while OWNED with ram_wren=1 → ram_wren and grant go 0 without waiting for a clock. After release, req=0010 → grant=0010 (round-robin restarted with last_owner=3).
